// File: rtl/xbit_seq_pkg.sv
// Shared types and constants for the CB-prefix bit/rotate sequencer.
package xbit_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH_DISP,
        S_FETCH_OP,
        S_CALC,
        S_MEM_RD,
        S_EXEC,
        S_MEM_WR
    } state_t;

    localparam logic [1:0] ADDR_PC  = 2'd0;
    localparam logic [1:0] ADDR_HL  = 2'd1;
    localparam logic [1:0] ADDR_IDX = 2'd2;

    localparam logic [1:0] GRP_ROT = 2'd0;
    localparam logic [1:0] GRP_BIT = 2'd1;
    localparam logic [1:0] GRP_RES = 2'd2;
    localparam logic [1:0] GRP_SET = 2'd3;

    localparam logic [2:0] REG_MEM = 3'b110;

endpackage

// File: rtl/xbit_seq_classify.sv
// Combinational classification of a CB opcode and its addressing form.
module xbit_seq_classify
    import xbit_seq_pkg::*;
(
    input  logic [7:0] op,
    input  logic       indexed,
    output logic       is_mem,
    output logic       is_bit,
    output logic       writes_reg,
    output logic       writes_flags
);

    assign is_mem       = indexed || (op[2:0] == REG_MEM);
    assign is_bit       = (op[7:6] == GRP_BIT);
    // Indexed forms with a register field also copy the result into that register.
    assign writes_reg   = (op[2:0] != REG_MEM) && !is_bit;
    assign writes_flags = (op[7:6] == GRP_ROT) || (op[7:6] == GRP_BIT);

endmodule

// File: rtl/xbit_sequencer.sv
// Sequencer for CB-prefixed bit/rotate instructions: fetches, read-modify-write and strobes.
module xbit_sequencer
    import xbit_seq_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic       indexed,
    input  logic [7:0] bus_data,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic [1:0] addr_sel,
    output logic       pc_inc,
    output logic [7:0] opcode,
    output logic [7:0] disp,
    output logic       mdr_load,
    output logic       alu_en,
    output logic [1:0] alu_group,
    output logic [2:0] alu_sel,
    output logic [2:0] reg_sel,
    output logic       reg_write,
    output logic       flags_write,
    output logic       busy,
    output logic       done
);

    state_t     state_q, state_d;
    logic       idx_q;
    logic [7:0] opcode_q, disp_q;
    logic [7:0] cls_op;
    logic       is_mem, is_bit, writes_reg, writes_flags;
    logic [1:0] mem_addr;

    xbit_seq_classify u_classify (
        .op          (cls_op),
        .indexed     (idx_q),
        .is_mem      (is_mem),
        .is_bit      (is_bit),
        .writes_reg  (writes_reg),
        .writes_flags(writes_flags)
    );

    assign mem_addr  = idx_q ? ADDR_IDX : ADDR_HL;
    assign opcode    = opcode_q;
    assign disp      = disp_q;
    assign alu_group = opcode_q[7:6];
    assign alu_sel   = opcode_q[5:3];
    assign reg_sel   = opcode_q[2:0];

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= S_IDLE;
            idx_q    <= 1'b0;
            opcode_q <= 8'h00;
            disp_q   <= 8'h00;
        end else begin
            state_q <= state_d;
            if (state_q == S_IDLE && start) begin
                idx_q <= indexed;
                if (!indexed) disp_q <= 8'h00;
            end
            if (state_q == S_FETCH_DISP && mem_ready) disp_q <= bus_data;
            if (state_q == S_FETCH_OP && mem_ready) opcode_q <= bus_data;
        end
    end

    always_comb begin
        state_d     = state_q;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        addr_sel    = ADDR_PC;
        pc_inc      = 1'b0;
        mdr_load    = 1'b0;
        alu_en      = 1'b0;
        reg_write   = 1'b0;
        flags_write = 1'b0;
        done        = 1'b0;
        busy        = (state_q != S_IDLE);
        cls_op      = opcode_q;
        case (state_q)
            S_IDLE: begin
                if (start) state_d = indexed ? S_FETCH_DISP : S_FETCH_OP;
            end
            S_FETCH_DISP: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    pc_inc  = 1'b1;
                    state_d = S_FETCH_OP;
                end
            end
            S_FETCH_OP: begin
                // The next state depends on the opcode arriving on the bus this cycle.
                mem_req = 1'b1;
                cls_op  = bus_data;
                if (mem_ready) begin
                    pc_inc = 1'b1;
                    if (idx_q)       state_d = S_CALC;
                    else if (is_mem) state_d = S_MEM_RD;
                    else             state_d = S_EXEC;
                end
            end
            S_CALC: begin
                addr_sel = ADDR_IDX;
                state_d  = S_MEM_RD;
            end
            S_MEM_RD: begin
                mem_req  = 1'b1;
                addr_sel = mem_addr;
                if (mem_ready) begin
                    mdr_load = 1'b1;
                    state_d  = S_EXEC;
                end
            end
            S_EXEC: begin
                alu_en      = 1'b1;
                reg_write   = writes_reg;
                flags_write = writes_flags;
                if (!is_mem || is_bit) begin
                    done    = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    state_d = S_MEM_WR;
                end
            end
            S_MEM_WR: begin
                mem_req  = 1'b1;
                mem_we   = 1'b1;
                addr_sel = mem_addr;
                if (mem_ready) begin
                    done    = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_xbit_sequencer.sv
// Self-checking bench: per-cycle output trace compared against a transaction-level model.
module tb_xbit_sequencer;

    logic       clock = 1'b0;
    logic       reset, start, indexed, mem_ready;
    logic [7:0] bus_data;
    logic       mem_req, mem_we, pc_inc, mdr_load, alu_en, reg_write, flags_write, busy, done;
    logic [1:0] addr_sel, alu_group;
    logic [2:0] alu_sel, reg_sel;
    logic [7:0] opcode, disp;

    int n_tests = 0;
    int n_fail  = 0;

    logic [10:0] exp_q[$];
    logic        rdy_q[$];
    logic [7:0]  bus_q[$];

    xbit_sequencer dut (
        .clock(clock), .reset(reset), .start(start), .indexed(indexed),
        .bus_data(bus_data), .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we),
        .addr_sel(addr_sel), .pc_inc(pc_inc), .opcode(opcode), .disp(disp),
        .mdr_load(mdr_load), .alu_en(alu_en), .alu_group(alu_group), .alu_sel(alu_sel),
        .reg_sel(reg_sel), .reg_write(reg_write), .flags_write(flags_write),
        .busy(busy), .done(done)
    );

    always #5 clock = ~clock;

    // {mem_req, mem_we, addr_sel, pc_inc, mdr_load, alu_en, reg_write, flags_write, busy, done}
    wire [10:0] obs = {mem_req, mem_we, addr_sel, pc_inc, mdr_load, alu_en,
                       reg_write, flags_write, busy, done};

    function automatic logic [10:0] mk(logic req, logic we, logic [1:0] a, logic pc, logic mdr,
                                       logic alu, logic rw, logic fw, logic bz, logic dn);
        return {req, we, a, pc, mdr, alu, rw, fw, bz, dn};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // One memory access: w wait cycles, then the completing cycle.
    // kind: 0 = PC fetch, 1 = read, 2 = write
    task automatic push_access(input int kind, input logic [1:0] a, input logic [7:0] data,
                               input int w);
        int waits;
        waits = (w < 0) ? $urandom_range(0, 2) : w;
        for (int i = 0; i < waits; i++) begin
            exp_q.push_back(mk(1, kind == 2, a, 0, 0, 0, 0, 0, 1, 0));
            rdy_q.push_back(1'b0);
            bus_q.push_back(8'($urandom));
        end
        exp_q.push_back(mk(1, kind == 2, a, kind == 0, kind == 1, 0, 0, 0, 1, kind == 2));
        rdy_q.push_back(1'b1);
        bus_q.push_back(data);
    endtask

    task automatic run_txn(input logic idx, input logic [7:0] d, input logic [7:0] op,
                           input int w, input logic [7:0] rd_val);
        logic       mem, is_bit, rmw, wr_reg, wr_flags;
        logic [1:0] ma;
        logic [7:0] exp_disp;
        mem      = idx || (op[2:0] == 3'b110);
        is_bit   = (op[7:6] == 2'd1);
        rmw      = mem && !is_bit;
        wr_reg   = (op[2:0] != 3'b110) && !is_bit;
        wr_flags = (op[7:6] < 2'd2);
        ma       = idx ? 2'd2 : 2'd1;
        exp_disp = idx ? d : 8'h00;

        if (idx) push_access(0, 2'd0, d, w);
        push_access(0, 2'd0, op, w);
        if (idx) begin
            exp_q.push_back(mk(0, 0, 2'd2, 0, 0, 0, 0, 0, 1, 0));
            rdy_q.push_back(1'($urandom));
            bus_q.push_back(8'($urandom));
        end
        if (mem) push_access(1, ma, rd_val, w);
        exp_q.push_back(mk(0, 0, 2'd0, 0, 0, 1, wr_reg, wr_flags, 1, !rmw));
        rdy_q.push_back(1'($urandom));
        bus_q.push_back(8'($urandom));
        if (rmw) push_access(2, ma, 8'($urandom), w);

        @(posedge clock); #1;
        start = 1'b1; indexed = idx; mem_ready = 1'($urandom); bus_data = 8'($urandom);
        @(negedge clock);
        check("start_cycle", 32'(obs), 32'd0);
        while (exp_q.size() > 0) begin
            @(posedge clock); #1;
            start     = ($urandom_range(0, 3) == 0);
            indexed   = 1'($urandom);
            mem_ready = rdy_q.pop_front();
            bus_data  = bus_q.pop_front();
            @(negedge clock);
            check("cycle", 32'(obs), 32'(exp_q.pop_front()));
        end
        @(posedge clock); #1;
        start = 1'b0; mem_ready = 1'($urandom);
        @(negedge clock);
        check("after_done", 32'(obs), 32'd0);
        check("opcode", 32'(opcode), 32'(op));
        check("disp", 32'(disp), 32'(exp_disp));
        check("fields", 32'({alu_group, alu_sel, reg_sel}), 32'(op));
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; indexed = 1'b0; mem_ready = 1'b0; bus_data = 8'h00;
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("reset_outputs", 32'(obs), 32'd0);
        check("reset_regs", 32'({opcode, disp, addr_sel}), 32'd0);
        @(posedge clock); #1;
        reset = 1'b0;

        run_txn(1'b0, 8'h00, 8'h00, 0, 8'h00);  // RLC B
        run_txn(1'b0, 8'h00, 8'h7E, 0, 8'h80);  // BIT 7,(HL)
        run_txn(1'b0, 8'h00, 8'hC6, 2, 8'h11);  // SET 0,(HL), two waits per access
        run_txn(1'b1, 8'h05, 8'h16, 0, 8'h22);  // RL (IX+5)
        run_txn(1'b1, 8'hFE, 8'h80, 0, 8'h33);  // RES 0,(IX-2),B

        // Abort a SET 0,(HL) by reset while its write is stalled.
        @(posedge clock); #1;
        start = 1'b1; indexed = 1'b0; mem_ready = 1'b0;
        @(posedge clock); #1;
        start = 1'b0; mem_ready = 1'b1; bus_data = 8'hC6;
        @(posedge clock); #1;
        mem_ready = 1'b1; bus_data = 8'h01;
        @(posedge clock); #1;
        mem_ready = 1'b0;
        @(posedge clock); #1;
        @(negedge clock);
        check("stalled_write", 32'(obs), 32'(mk(1, 1, 2'd1, 0, 0, 0, 0, 0, 1, 0)));
        @(posedge clock); #1;
        reset = 1'b1;
        @(negedge clock);
        check("write_in_reset_cycle", 32'(obs), 32'(mk(1, 1, 2'd1, 0, 0, 0, 0, 0, 1, 0)));
        @(posedge clock); #1;
        reset = 1'b0;
        @(negedge clock);
        check("abort_outputs", 32'(obs), 32'd0);
        check("abort_opcode", 32'(opcode), 32'd0);

        for (int t = 0; t < 40; t++) begin
            run_txn(1'($urandom), 8'($urandom), 8'($urandom), -1, 8'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
